// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: synchronises device request lines, latches
// rising edges as pending bits and presents one masked request at a time to the SRF.
module interrupt_controller #(
  parameter int N_SRC     = 4,
  parameter int IDN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_SRC-1:0]     srcIn,
  input  logic                 maskWe,
  input  logic [N_SRC-1:0]     maskData,
  input  logic                 intrAck,
  input  logic                 reti,
  output logic                 irq,
  output logic [IDN_WIDTH-1:0] idn,
  output logic [N_SRC-1:0]     pendOut,
  output logic                 inService
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_SRC-1:0]     r_sync1;
  logic [N_SRC-1:0]     r_sync2;
  logic [N_SRC-1:0]     r_prev;
  logic [N_SRC-1:0]     r_pend;
  logic [N_SRC-1:0]     r_mask;
  logic [N_SRC-1:0]     w_rise;
  logic [N_SRC-1:0]     w_elig;
  logic [N_SRC-1:0]     w_idn_oh;
  logic [N_SRC-1:0]     w_clr;
  logic                 w_held;
  logic                 w_accept;
  logic [IDN_WIDTH-1:0] w_win;
  logic [IDN_WIDTH-1:0] r_idn;
  logic [IDN_WIDTH-1:0] w_idn_nxt;
  logic                 r_irq;
  logic                 w_irq_nxt;
  logic                 r_in_svc;
  logic                 w_in_svc_nxt;

  assign w_rise   = r_sync2 & ~r_prev;
  assign w_elig   = r_pend & r_mask;
  assign w_idn_oh = {{(N_SRC-1){1'b0}}, 1'b1} << r_idn;
  assign w_held   = |(w_idn_oh & r_pend & r_mask);
  assign w_accept = (r_state == ST_REQ) && intrAck;
  assign w_clr    = w_accept ? w_idn_oh : {N_SRC{1'b0}};

  // Lowest-index eligible source wins arbitration.
  always_comb begin
    w_win = {IDN_WIDTH{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win = IDN_WIDTH'(i);
      end else begin
        w_win = w_win;
      end
    end
  end

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {N_SRC{1'b0}};
      r_sync2 <= {N_SRC{1'b0}};
      r_prev  <= {N_SRC{1'b0}};
    end else begin
      r_sync1 <= srcIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Pending and mask registers; a new edge overrides a same-cycle accept clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= {N_SRC{1'b0}};
      r_mask <= {N_SRC{1'b1}};
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (maskWe) begin
        r_mask <= maskData;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; idn is frozen while a request is outstanding.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (intrAck) begin
          w_state_nxt = ST_SERVICE;
        end else if (!w_held) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (reti) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SERVICE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic, computed from the next state so outputs can be registered.
  always_comb begin
    w_irq_nxt    = (w_state_nxt == ST_REQ);
    w_in_svc_nxt = (w_state_nxt == ST_SERVICE);
    if ((r_state == ST_IDLE) && (w_state_nxt == ST_REQ)) begin
      w_idn_nxt = w_win;
    end else begin
      w_idn_nxt = r_idn;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq    <= 1'b0;
      r_idn    <= {IDN_WIDTH{1'b0}};
      r_in_svc <= 1'b0;
    end else begin
      r_irq    <= w_irq_nxt;
      r_idn    <= w_idn_nxt;
      r_in_svc <= w_in_svc_nxt;
    end
  end

  assign irq       = r_irq;
  assign idn       = r_idn;
  assign pendOut   = r_pend;
  assign inService = r_in_svc;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed vector table, hand-written
// corner sequences and randomised traffic compared against a history-based model.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] srcIn;
  logic       maskWe;
  logic [3:0] maskData;
  logic       intrAck;
  logic       reti;
  logic       irq;
  logic [3:0] idn;
  logic [3:0] pendOut;
  logic       inService;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.N_SRC(4), .IDN_WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .srcIn     (srcIn),
    .maskWe    (maskWe),
    .maskData  (maskData),
    .intrAck   (intrAck),
    .reti      (reti),
    .irq       (irq),
    .idn       (idn),
    .pendOut   (pendOut),
    .inService (inService)
  );

  // Reference model: source history queue (newest first), pending set, mode 0/1/2.
  logic [3:0] q_src[$];
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  int         m_mode;
  int         m_idn;

  typedef struct {
    logic [3:0] src;
    logic       ack;
    logic       rt;
    logic       e_irq;
    logic [3:0] e_idn;
    logic [3:0] e_pend;
    logic       e_svc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_src  = {4'h0, 4'h0, 4'h0};
    m_pend = 4'h0;
    m_mask = 4'hF;
    m_mode = 0;
    m_idn  = 0;
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] elig;
    logic [3:0] low;
    // a source rises at this edge if it was seen 1 two edges ago and 0 three edges ago
    rise = q_src[1] & ~q_src[2];
    clr  = 4'h0;
    elig = m_pend & m_mask;
    case (m_mode)
      0: if (elig != 4'h0) begin
           low    = elig & (~elig + 4'd1);
           m_idn  = $clog2(low);
           m_mode = 1;
         end
      1: if (intrAck) begin
           clr[m_idn] = 1'b1;
           m_mode     = 2;
         end else if (!(m_pend[m_idn] && m_mask[m_idn])) begin
           m_mode = 0;
         end
      2: if (reti) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    if (maskWe) m_mask = maskData;
    q_src.push_front(srcIn);
    void'(q_src.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    chk("model_irq", {31'd0, irq}, {31'd0, m_mode == 1});
    chk("model_insvc", {31'd0, inService}, {31'd0, m_mode == 2});
    chk("model_pend", {28'd0, pendOut}, {28'd0, m_pend});
    if (m_mode == 1) chk("model_idn", {28'd0, idn}, m_idn);
  endtask

  task automatic wait_irq(input string name);
    int k;
    k = 0;
    while (!irq && k < 10) begin
      step();
      k++;
    end
    chk(name, {31'd0, irq}, 32'd1);
  endtask

  task automatic ack_reti_clear();
    intrAck = 1'b1; step(); intrAck = 1'b0;
    reti = 1'b1; step(); reti = 1'b0;
    srcIn = 4'h0;
    repeat (3) step();
  endtask

  task automatic add(input logic [3:0] s, input logic a, input logic r,
                     input logic ei, input logic [3:0] eid, input logic [3:0] ep, input logic es);
    vec_t v;
    v.src = s; v.ack = a; v.rt = r; v.e_irq = ei; v.e_idn = eid; v.e_pend = ep; v.e_svc = es;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; srcIn = 4'h0; maskWe = 1'b0; maskData = 4'h0; intrAck = 1'b0; reti = 1'b0;
    model_reset();
    repeat (2) step();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_idn", {28'd0, idn}, 32'd0);
    chk("rst_pend", {28'd0, pendOut}, 32'd0);
    chk("rst_insvc", {31'd0, inService}, 32'd0);
    reset_n = 1'b1;
    step();

    // single source latency, then two simultaneous sources
    add(4'h4, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'h4, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'h4, 0, 0, 0, 4'h0, 4'h4, 0);
    add(4'h4, 0, 0, 1, 4'h2, 4'h4, 0);
    add(4'h4, 1, 0, 0, 4'h0, 4'h0, 1);
    add(4'h4, 0, 1, 0, 4'h0, 4'h0, 0);
    add(4'h4, 0, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) add(4'h0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'hA, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'hA, 0, 0, 0, 4'h0, 4'h0, 0);
    add(4'hA, 0, 0, 0, 4'h0, 4'hA, 0);
    add(4'hA, 0, 0, 1, 4'h1, 4'hA, 0);
    add(4'hA, 1, 0, 0, 4'h0, 4'h8, 1);
    add(4'hA, 0, 1, 0, 4'h0, 4'h8, 0);
    add(4'hA, 0, 0, 1, 4'h3, 4'h8, 0);
    add(4'hA, 1, 0, 0, 4'h0, 4'h0, 1);
    add(4'hA, 0, 1, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) add(4'h0, 0, 0, 0, 4'h0, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      srcIn = vecs[i].src; intrAck = vecs[i].ack; reti = vecs[i].rt;
      step();
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].e_irq});
      chk($sformatf("vec%0d_pend", i), {28'd0, pendOut}, {28'd0, vecs[i].e_pend});
      chk($sformatf("vec%0d_insvc", i), {31'd0, inService}, {31'd0, vecs[i].e_svc});
      if (vecs[i].e_irq) chk($sformatf("vec%0d_idn", i), {28'd0, idn}, {28'd0, vecs[i].e_idn});
    end
    intrAck = 1'b0; reti = 1'b0;

    // masking withdraws an outstanding request; unmasking re-issues it
    srcIn = 4'h1;
    wait_irq("t3_req");
    chk("t3_idn", {28'd0, idn}, 32'd0);
    maskWe = 1'b1; maskData = 4'hE; step(); maskWe = 1'b0;
    step();
    chk("t3_masked_irq", {31'd0, irq}, 32'd0);
    chk("t3_pend0_kept", {31'd0, pendOut[0]}, 32'd1);
    repeat (2) step();
    chk("t3_still_masked", {31'd0, irq}, 32'd0);
    maskWe = 1'b1; maskData = 4'hF; step(); maskWe = 1'b0;
    step();
    chk("t3_unmask_irq", {31'd0, irq}, 32'd1);
    chk("t3_unmask_idn", {28'd0, idn}, 32'd0);
    ack_reti_clear();

    // request held without ack; new edge during service waits for reti
    srcIn = 4'h2;
    wait_irq("t4_req");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_hold_irq", {31'd0, irq}, 32'd1);
      chk("t4_hold_idn", {28'd0, idn}, 32'd1);
    end
    intrAck = 1'b1; step(); intrAck = 1'b0;
    chk("t4_ack_irq", {31'd0, irq}, 32'd0);
    chk("t4_ack_insvc", {31'd0, inService}, 32'd1);
    srcIn = 4'h3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_svc_noirq", {31'd0, irq}, 32'd0);
    end
    chk("t4_svc_pend", {28'd0, pendOut}, 32'd1);
    reti = 1'b1; step(); reti = 1'b0;
    chk("t4_reti_insvc", {31'd0, inService}, 32'd0);
    chk("t4_gap_irq", {31'd0, irq}, 32'd0);
    step();
    chk("t4_rearb_irq", {31'd0, irq}, 32'd1);
    chk("t4_rearb_idn", {28'd0, idn}, 32'd0);
    ack_reti_clear();

    // new edge landing in the same cycle as the accept clear survives
    srcIn = 4'h4;
    wait_irq("t5_req");
    chk("t5_idn", {28'd0, idn}, 32'd2);
    srcIn = 4'h0;
    repeat (3) step();
    srcIn = 4'h4;
    step(); step();
    intrAck = 1'b1; step(); intrAck = 1'b0;
    chk("t5_setwins_pend", {31'd0, pendOut[2]}, 32'd1);
    chk("t5_ack_insvc", {31'd0, inService}, 32'd1);
    reti = 1'b1; step(); reti = 1'b0;
    step();
    chk("t5_second_irq", {31'd0, irq}, 32'd1);
    chk("t5_second_idn", {28'd0, idn}, 32'd2);
    ack_reti_clear();

    // asynchronous reset while in service
    srcIn = 4'h1;
    wait_irq("t6_req");
    intrAck = 1'b1; step(); intrAck = 1'b0;
    chk("t6_insvc", {31'd0, inService}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_insvc", {31'd0, inService}, 32'd0);
    chk("t6_async_pend", {28'd0, pendOut}, 32'd0);
    chk("t6_async_irq", {31'd0, irq}, 32'd0);
    srcIn = 4'h0;
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_post_irq", {31'd0, irq}, 32'd0);
    end
    srcIn = 4'h2;
    wait_irq("t6_fresh_req");
    chk("t6_fresh_idn", {28'd0, idn}, 32'd1);
    ack_reti_clear();

    // randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) srcIn = srcIn ^ (4'd1 << $urandom_range(0, 3));
      intrAck  = ($urandom_range(0, 3) == 0);
      reti     = ($urandom_range(0, 4) == 0);
      maskWe   = ($urandom_range(0, 19) == 0);
      maskData = 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
